// File: rtl/ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_if
// Bundles every signal of the ID/EX operand stage except clk and rst.
//
// Signal groups:
//   decode   : id_valid, id_pc, id_rs1/rs2_data, id_rs1/rs2/rd_addr, id_imm,
//              id_alu_op, id_sel_a, id_sel_b, id_reg_wr, id_mem_rd
//   control  : flush (kill entering instruction), ex_hold (downstream stall)
//   bypass   : mem_rd_addr/mem_reg_wr/mem_result, wb_rd_addr/wb_reg_wr/wb_result
//   results  : alu_a, alu_b, alu_op, ex_valid, ex_rd_addr, ex_reg_wr,
//              ex_mem_rd, ex_store_data, stall_id
//
// Modports:
//   master : the pipeline around the stage (drives decode/bypass/control)
//   slave  : the operand stage itself
// ---------------------------------------------------------------------------
interface ex_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [RA_W-1:0] id_rs1_addr;
    logic [RA_W-1:0] id_rs2_addr;
    logic [RA_W-1:0] id_rd_addr;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_alu_op;
    logic            id_sel_a;
    logic            id_sel_b;
    logic            id_reg_wr;
    logic            id_mem_rd;

    logic            flush;
    logic            ex_hold;

    logic [RA_W-1:0] mem_rd_addr;
    logic            mem_reg_wr;
    logic [XLEN-1:0] mem_result;
    logic [RA_W-1:0] wb_rd_addr;
    logic            wb_reg_wr;
    logic [XLEN-1:0] wb_result;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic            ex_valid;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_reg_wr;
    logic            ex_mem_rd;
    logic [XLEN-1:0] ex_store_data;
    logic            stall_id;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr,
               id_rs2_addr, id_rd_addr, id_imm, id_alu_op, id_sel_a,
               id_sel_b, id_reg_wr, id_mem_rd, flush, ex_hold,
               mem_rd_addr, mem_reg_wr, mem_result,
               wb_rd_addr, wb_reg_wr, wb_result,
        input  alu_a, alu_b, alu_op, ex_valid, ex_rd_addr, ex_reg_wr,
               ex_mem_rd, ex_store_data, stall_id
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr,
               id_rs2_addr, id_rd_addr, id_imm, id_alu_op, id_sel_a,
               id_sel_b, id_reg_wr, id_mem_rd, flush, ex_hold,
               mem_rd_addr, mem_reg_wr, mem_result,
               wb_rd_addr, wb_reg_wr, wb_result,
        output alu_a, alu_b, alu_op, ex_valid, ex_rd_addr, ex_reg_wr,
               ex_mem_rd, ex_store_data, stall_id
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register plus operand selection in front of the ALU.
// Captures decoded fields, forwards results from MEM/WB to the registered
// source operands, picks PC/immediate operands, and stalls decode on a
// load-use hazard by inserting a bubble.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears all EX state
//   bus  : ex_operand_stage_if.slave (decode fields, flush/ex_hold,
//          MEM/WB bypass info in; ALU operands, EX status, stall_id out)
// ---------------------------------------------------------------------------
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    ex_operand_stage_if.slave     bus
);

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [RA_W-1:0] ex_rs1_addr;
    logic [RA_W-1:0] ex_rs2_addr;
    logic [RA_W-1:0] ex_rd_addr;
    logic [XLEN-1:0] ex_imm;
    logic [3:0]      ex_alu_op;
    logic            ex_sel_a;
    logic            ex_sel_b;
    logic            ex_reg_wr;
    logic            ex_mem_rd;

    logic            haz;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load-use hazard: the load in EX cannot supply its data in time for the
    // instruction in decode. rs2 only matters when it is actually the B
    // operand source; rs1 is checked unconditionally because PC-relative
    // instructions never name a live rs1.
    always_comb begin
        haz = 1'b0;
        if (ex_valid && ex_mem_rd && ex_reg_wr && (ex_rd_addr != '0) && bus.id_valid) begin
            if ((ex_rd_addr == bus.id_rs1_addr) ||
                ((ex_rd_addr == bus.id_rs2_addr) && !bus.id_sel_b)) begin
                haz = 1'b1;
            end
        end
    end

    // Bypass network on the registered source indices. MEM holds the younger
    // result, so it beats WB. x0 is never bypassed; its captured data is 0.
    always_comb begin
        fwd_rs1 = ex_rs1_data;
        if (bus.mem_reg_wr && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == ex_rs1_addr)) begin
            fwd_rs1 = bus.mem_result;
        end else if (bus.wb_reg_wr && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == ex_rs1_addr)) begin
            fwd_rs1 = bus.wb_result;
        end
    end

    always_comb begin
        fwd_rs2 = ex_rs2_data;
        if (bus.mem_reg_wr && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == ex_rs2_addr)) begin
            fwd_rs2 = bus.mem_result;
        end else if (bus.wb_reg_wr && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == ex_rs2_addr)) begin
            fwd_rs2 = bus.wb_result;
        end
    end

    // EX register. Flush beats hold so a killed instruction cannot linger
    // behind a downstream stall; a bubble only clears the control bits and
    // opcode, leaving data fields as don't-care leftovers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_imm      <= '0;
            ex_alu_op   <= '0;
            ex_sel_a    <= 1'b0;
            ex_sel_b    <= 1'b0;
            ex_reg_wr   <= 1'b0;
            ex_mem_rd   <= 1'b0;
        end else if (bus.flush) begin
            ex_valid    <= 1'b0;
            ex_reg_wr   <= 1'b0;
            ex_mem_rd   <= 1'b0;
        end else if (bus.ex_hold) begin
            ex_valid    <= ex_valid;
        end else if (haz) begin
            ex_valid    <= 1'b0;
            ex_reg_wr   <= 1'b0;
            ex_mem_rd   <= 1'b0;
            ex_alu_op   <= '0;
        end else begin
            ex_valid    <= bus.id_valid;
            ex_pc       <= bus.id_pc;
            ex_rs1_data <= bus.id_rs1_data;
            ex_rs2_data <= bus.id_rs2_data;
            ex_rs1_addr <= bus.id_rs1_addr;
            ex_rs2_addr <= bus.id_rs2_addr;
            ex_rd_addr  <= bus.id_rd_addr;
            ex_imm      <= bus.id_imm;
            ex_alu_op   <= bus.id_alu_op;
            ex_sel_a    <= bus.id_sel_a;
            ex_sel_b    <= bus.id_sel_b;
            ex_reg_wr   <= bus.id_reg_wr & bus.id_valid;
            ex_mem_rd   <= bus.id_mem_rd & bus.id_valid;
        end
    end

    assign bus.alu_a         = ex_sel_a ? ex_pc  : fwd_rs1;
    assign bus.alu_b         = ex_sel_b ? ex_imm : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.alu_op        = ex_alu_op;
    assign bus.ex_valid      = ex_valid;
    assign bus.ex_rd_addr    = ex_rd_addr;
    assign bus.ex_reg_wr     = ex_reg_wr;
    assign bus.ex_mem_rd     = ex_mem_rd;
    assign bus.stall_id      = haz | bus.ex_hold;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
// Self-checking bench for ex_operand_stage. Each scenario task pushes the
// expected EX-stage view onto a scoreboard queue as it drives stimulus, then
// pops and compares it against the sampled DUT outputs.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic        valid;
        logic        reg_wr;
        logic        mem_rd;
        logic        stall;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
    } obs_t;

    typedef struct {
        string name;
        obs_t  val;
    } exp_t;

    logic clk;
    logic rst;
    exp_t scb[$];
    int   n_cmp;
    int   n_bad;

    ex_operand_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t ob(input logic v, input logic rw, input logic mr, input logic st,
                                input logic [3:0] op, input logic [4:0] rd,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        obs_t o;
        o.valid = v; o.reg_wr = rw; o.mem_rd = mr; o.stall = st;
        o.op = op; o.rd = rd; o.a = a; o.b = b; o.store = s;
        return o;
    endfunction

    function automatic obs_t sample();
        return ob(bus.ex_valid, bus.ex_reg_wr, bus.ex_mem_rd, bus.stall_id, bus.alu_op,
                  bus.ex_rd_addr, bus.alu_a, bus.alu_b, bus.ex_store_data);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] rs1d,
                            input logic [31:0] rs2d, input logic [4:0] rs1a, input logic [4:0] rs2a,
                            input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] op,
                            input logic sa, input logic sb, input logic rw, input logic mr);
        bus.id_valid = v;       bus.id_pc = pc;
        bus.id_rs1_data = rs1d; bus.id_rs2_data = rs2d;
        bus.id_rs1_addr = rs1a; bus.id_rs2_addr = rs2a; bus.id_rd_addr = rd;
        bus.id_imm = imm;       bus.id_alu_op = op;
        bus.id_sel_a = sa;      bus.id_sel_b = sb;
        bus.id_reg_wr = rw;     bus.id_mem_rd = mr;
    endtask

    task automatic clear_fwd();
        bus.mem_rd_addr = '0; bus.mem_reg_wr = 1'b0; bus.mem_result = '0;
        bus.wb_rd_addr  = '0; bus.wb_reg_wr  = 1'b0; bus.wb_result  = '0;
    endtask

    task automatic test_reset();
        exp_t e; obs_t o;
        repeat (2) tick();
        scb.push_back('{"reset_initial", ob(0,0,0,0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0)});
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        rst = 1'b0;
        drive_id(1, 32'h40, 32'd5, 32'd6, 5'd1, 5'd2, 5'd7, 32'h0, 4'd0, 0, 0, 1, 0);
        scb.push_back('{"reset_pre", ob(1,1,0,0, 4'd0, 5'd7, 32'd5, 32'd6, 32'd6)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        #3 rst = 1'b1;
        #1;
        scb.push_back('{"reset_async", ob(0,0,0,0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0)});
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        scb.push_back('{"reset_held", ob(0,0,0,0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t o;
        clear_fwd();
        // ADD x3, x1, x2
        drive_id(1, 32'h10, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 32'h0, 4'd0, 0, 0, 1, 0);
        scb.push_back('{"b2b_add", ob(1,1,0,0, 4'd0, 5'd3, 32'h1, 32'h2, 32'h2)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        // SUB x4, x3, x1 with stale regfile value for x3
        drive_id(1, 32'h14, 32'hAAAA, 32'h1, 5'd3, 5'd1, 5'd4, 32'h0, 4'd1, 0, 0, 1, 0);
        tick();
        bus.mem_rd_addr = 5'd3; bus.mem_reg_wr = 1'b1; bus.mem_result = 32'h10;
        scb.push_back('{"b2b_mem_fwd", ob(1,1,0,0, 4'd1, 5'd4, 32'h10, 32'h1, 32'h1)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.wb_rd_addr = 5'd3; bus.wb_reg_wr = 1'b1; bus.wb_result = 32'h99;
        scb.push_back('{"b2b_mem_wins", ob(1,1,0,0, 4'd1, 5'd4, 32'h10, 32'h1, 32'h1)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.mem_reg_wr = 1'b0;
        scb.push_back('{"b2b_wb_fwd", ob(1,1,0,0, 4'd1, 5'd4, 32'h99, 32'h1, 32'h1)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.wb_rd_addr = 5'd1; bus.wb_result = 32'h55;
        scb.push_back('{"b2b_rs2_fwd", ob(1,1,0,0, 4'd1, 5'd4, 32'hAAAA, 32'h55, 32'h55)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        clear_fwd();
    endtask

    task automatic test_load_use();
        exp_t e; obs_t o;
        clear_fwd();
        // LW x5, 0(x1)
        drive_id(1, 32'h20, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd5, 32'h0, 4'd0, 0, 1, 1, 1);
        scb.push_back('{"lu_load", ob(1,1,1,0, 4'd0, 5'd5, 32'h1000, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        // ADD x6, x5, x0
        drive_id(1, 32'h24, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 32'h0, 4'd0, 0, 0, 1, 0);
        scb.push_back('{"lu_stall", ob(1,1,1,1, 4'd0, 5'd5, 32'h1000, 32'h0, 32'h0)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        scb.push_back('{"lu_bubble", ob(0,0,0,0, 4'd0, 5'd5, 32'h1000, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        tick();
        bus.wb_rd_addr = 5'd5; bus.wb_reg_wr = 1'b1; bus.wb_result = 32'hDEADBEEF;
        scb.push_back('{"lu_wb_fwd", ob(1,1,0,0, 4'd0, 5'd6, 32'hDEADBEEF, 32'h0, 32'h0)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        clear_fwd();
        // Load again; consumer names x5 only as rs2 while B comes from imm
        drive_id(1, 32'h28, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd5, 32'h0, 4'd0, 0, 1, 1, 1);
        tick();
        drive_id(1, 32'h2C, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7, 32'h4, 4'd0, 0, 1, 1, 0);
        scb.push_back('{"lu_selb_nostall", ob(1,1,1,0, 4'd0, 5'd5, 32'h1000, 32'h0, 32'h0)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.id_sel_b = 1'b0;
        scb.push_back('{"lu_rs2_stall", ob(1,1,1,1, 4'd0, 5'd5, 32'h1000, 32'h0, 32'h0)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        drive_id(0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic test_x0_guard();
        exp_t e; obs_t o;
        clear_fwd();
        drive_id(1, 32'h30, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 32'h0, 4'd0, 0, 0, 1, 0);
        tick();
        bus.mem_rd_addr = 5'd0; bus.mem_reg_wr = 1'b1; bus.mem_result = 32'h1234;
        bus.wb_rd_addr  = 5'd0; bus.wb_reg_wr  = 1'b1; bus.wb_result  = 32'h77;
        scb.push_back('{"x0_guard", ob(1,1,0,0, 4'd0, 5'd8, 32'h0, 32'h0, 32'h0)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        clear_fwd();
    endtask

    task automatic test_operand_select();
        exp_t e; obs_t o;
        clear_fwd();
        drive_id(1, 32'h100, 32'h11, 32'h22, 5'd1, 5'd2, 5'd9, 32'hFFFFFFFC, 4'd0, 1, 1, 1, 0);
        scb.push_back('{"opsel_pc_imm", ob(1,1,0,0, 4'd0, 5'd9, 32'h100, 32'hFFFFFFFC, 32'h22)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.mem_rd_addr = 5'd2; bus.mem_reg_wr = 1'b1; bus.mem_result = 32'h33;
        scb.push_back('{"opsel_store_fwd", ob(1,1,0,0, 4'd0, 5'd9, 32'h100, 32'hFFFFFFFC, 32'h33)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.mem_rd_addr = 5'd1;
        scb.push_back('{"opsel_pc_ignores_fwd", ob(1,1,0,0, 4'd0, 5'd9, 32'h100, 32'hFFFFFFFC, 32'h22)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        clear_fwd();
    endtask

    task automatic test_priority();
        exp_t e; obs_t o;
        clear_fwd();
        drive_id(1, 32'h200, 32'h0, 32'h0, 5'd0, 5'd0, 5'd10, 32'h0, 4'd5, 1, 0, 1, 0);
        scb.push_back('{"prio_capture", ob(1,1,0,0, 4'd5, 5'd10, 32'h200, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        drive_id(1, 32'h300, 32'h0, 32'h0, 5'd0, 5'd0, 5'd11, 32'h0, 4'd2, 1, 0, 1, 0);
        bus.ex_hold = 1'b1;
        scb.push_back('{"prio_hold_stall", ob(1,1,0,1, 4'd5, 5'd10, 32'h200, 32'h0, 32'h0)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        for (int i = 0; i < 3; i++) begin
            scb.push_back('{$sformatf("prio_hold_cycle%0d", i), ob(1,1,0,1, 4'd5, 5'd10, 32'h200, 32'h0, 32'h0)});
            tick();
            e = scb.pop_front(); o = sample(); n_cmp++;
            if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        end
        bus.flush = 1'b1;
        scb.push_back('{"prio_flush_over_hold", ob(0,0,0,1, 4'd5, 5'd10, 32'h200, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.flush = 1'b0; bus.ex_hold = 1'b0;
        scb.push_back('{"prio_release", ob(1,1,0,0, 4'd2, 5'd11, 32'h300, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        // Load with a non-zero opcode so a flush (keeps opcode) is
        // distinguishable from a bubble (zeroes opcode).
        drive_id(1, 32'h400, 32'h8, 32'h0, 5'd1, 5'd0, 5'd5, 32'h0, 4'd3, 0, 1, 1, 1);
        scb.push_back('{"prio_load", ob(1,1,1,0, 4'd3, 5'd5, 32'h8, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        drive_id(1, 32'h404, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 32'h0, 4'd0, 0, 0, 1, 0);
        bus.flush = 1'b1;
        scb.push_back('{"prio_haz_stall", ob(1,1,1,1, 4'd3, 5'd5, 32'h8, 32'h0, 32'h0)});
        #1;
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        scb.push_back('{"prio_flush_over_haz", ob(0,0,0,0, 4'd3, 5'd5, 32'h8, 32'h0, 32'h0)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
        bus.flush = 1'b0;
        // Invalid decode slot must not leak reg_wr/mem_rd into EX
        drive_id(0, 32'h0, 32'h7, 32'h9, 5'd1, 5'd2, 5'd12, 32'h0, 4'd4, 0, 0, 1, 1);
        scb.push_back('{"prio_invalid_gating", ob(0,0,0,0, 4'd4, 5'd12, 32'h7, 32'h9, 32'h9)});
        tick();
        e = scb.pop_front(); o = sample(); n_cmp++;
        if (o !== e.val) begin n_bad++; $display("[TB] FAIL %s got %h want %h", e.name, o, e.val); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.ex_hold = 1'b0;
        clear_fwd();
        drive_id(0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 0, 0, 0, 0);
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_guard();
        test_operand_select();
        test_priority();
        n_cmp++;
        if (scb.size() !== 0) begin
            n_bad++;
            $display("[TB] FAIL scoreboard_drain got %0d entries want 0", scb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU.
- Captures decoded instruction fields from decode and resolves RAW hazards by forwarding from the MEM and WB stages.
- Selects PC/immediate operands and drives the ALU's a, b and alu_op inputs.
- Detects load-use hazards, stalls decode and inserts a bubble.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W  source/destination indices.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_op  in  4  ALU opcode: 0 ADD … 12 pass-B.
- id_sel_a  in  1  0: rs1, 1: PC.
- id_sel_b  in  1  0: rs2, 1: imm.
- id_reg_wr  in  1  instruction writes rd.
- id_mem_rd  in  1  instruction is a load.
- flush  in  1  branch/exception kill of the instruction entering EX.
- ex_hold  in  1  downstream stall; freeze EX register.
- mem_rd_addr  in  RA_W, mem_reg_wr  in  1, mem_result  in  XLEN  MEM-stage writeback info.
- wb_rd_addr  in  RA_W, wb_reg_wr  in  1, wb_result  in  XLEN  WB-stage writeback info.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_op  out  4  ALU opcode.
- ex_valid  out  1  EX holds a valid instruction.
- ex_rd_addr  out  RA_W, ex_reg_wr  out  1, ex_mem_rd  out  1  forwarded down the pipe.
- ex_store_data  out  XLEN  forwarded rs2 value, for stores.
- stall_id  out  1  decode/fetch must hold.

Behaviour:
- Reset: all EX registers cleared.
  - ex_valid=0, alu_op=0, ex_rd_addr=0, ex_reg_wr=0, ex_mem_rd=0.
  - Stored pc/rs/imm=0, so alu_a=alu_b=ex_store_data=0 and stall_id=0.
  - Reset asserted mid-operation discards the in-flight instruction immediately; there is no clock dependency.
- Load-use hazard is combinational. haz=1 when ALL of:
  - ex_valid & ex_mem_rd & ex_reg_wr.
  - ex_rd_addr!=0.
  - id_valid.
  - ex_rd_addr equals id_rs1_addr, or equals id_rs2_addr with id_sel_b=0.
  - Note: rs1 always counts, because a PC-select instruction never marks rs1 live.
- stall_id = haz | ex_hold.
- Register update each rising edge, first match wins:
  1. flush: ex_valid<=0, ex_reg_wr<=0, ex_mem_rd<=0. Flush overrides hold and haz.
  2. ex_hold: all EX registers keep their value.
  3. haz: insert bubble. ex_valid<=0, ex_reg_wr<=0, ex_mem_rd<=0, alu_op<=0. Decode holds, so the instruction is captured one cycle later.
  4. otherwise: capture all id_* fields. ex_valid<=id_valid, and reg_wr/mem_rd are gated by id_valid.
- Forwarding is combinational on registered rs1/rs2, with this priority:
  - MEM first: if mem_reg_wr & mem_rd_addr!=0 & mem_rd_addr==rsN, use mem_result.
  - Then WB: same rule using wb_*, use wb_result.
  - Otherwise use the registered regfile data.
  - Register x0 is never forwarded; x0 reads return the captured data, which the regfile guarantees to be 0.
- Operands:
  - alu_a = sel_a ? pc : fwd_rs1.
  - alu_b = sel_b ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, regardless of sel_b.
- Latency: decode fields appear at the ALU one cycle after capture. Forwarded values track the MEM/WB inputs within the same cycle.
- While ex_hold is high, forwarding keeps re-evaluating. The outputs may change as MEM/WB advance; this is intended.
- A bubble must never assert ex_reg_wr or ex_mem_rd.

Test Plan:
- Reset: rst=1 mid-stream with id_valid=1 → next observation shows ex_valid=0, alu_a=alu_b=0, alu_op=0, stall_id=0.
- Back-to-back ADD x3,x1,x2 then SUB x4,x3,x1:
  - At SUB in EX, mem_rd_addr=3, mem_reg_wr=1, mem_result=0x0000_0010 → alu_a=0x10.
  - With WB also writing x3=0x99, MEM still wins: alu_a=0x10.
- Load-use: LW x5 in EX (ex_mem_rd=1, rd=5), decode ADD x6,x5,x0 → stall_id=1 for exactly one cycle. Next cycle ex_valid=0 and ex_reg_wr=0. Following cycle the ADD is captured; with wb_rd_addr=5, wb_result=0xDEAD_BEEF → alu_a=0xDEADBEEF.
- x0 guard: mem_rd_addr=0, mem_reg_wr=1, mem_result=0x1234, EX instruction reads x0 with id_rs1_data=0 → alu_a=0.
- Operand select: sel_a=1, pc=0x100; sel_b=1, imm=0xFFFF_FFFC; alu_op=0 → alu_a=0x100, alu_b=0xFFFFFFFC. ex_store_data still equals forwarded rs2.
- Priority:
  - flush and ex_hold both high → ex_valid=0 next cycle.
  - ex_hold alone for 3 cycles → alu_op, ex_rd_addr and pc unchanged, with stall_id=1 throughout.
  - haz with flush → flush wins and ex_valid=0.
